// File: rtl/bus_initiator.sv
// Single-outstanding initiator for the 32-bit pipelined Wishbone-style bus.
// One command in flight: strobe until accepted, wait for ack/err/timeout.
module bus_initiator #(
    parameter int AddrWidth     = 30,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [AddrWidth-1:0] cmd_addr,
    input  logic [31:0]          cmd_data,
    input  logic [3:0]           cmd_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 bus_cyc,
    output logic                 bus_stb,
    output logic                 bus_we,
    output logic [AddrWidth-1:0] bus_addr,
    output logic [3:0]           bus_sel,
    output logic [31:0]          bus_data_m,
    input  logic [31:0]          bus_data_s,
    input  logic                 bus_ack,
    input  logic                 bus_stall,
    input  logic                 bus_err
);

    localparam int CntW =
        (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_inc;
    logic            busy;
    logic            take;
    logic            done;
    logic            timeout;

    assign busy    = (state == REQ) || (state == WAIT);
    assign take    = (state == IDLE) && cmd_valid;
    assign cnt_inc = (cnt == CntMax) ? cnt : cnt + 1'b1;

    // ack/err count only once the strobe has been accepted
    assign done = (((state == REQ) && !bus_stall) || (state == WAIT))
                  && (bus_ack || bus_err);

    assign timeout = (TimeoutCycles != 0) && busy
                     && (cnt_inc == CntMax);

    assign cmd_ready = (state == IDLE) && rst_n;
    assign bus_cyc   = busy;
    assign bus_stb   = (state == REQ);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (cmd_valid) state_nx = REQ;
            end
            REQ: begin
                if (done || timeout) state_nx = RESP;
                else if (!bus_stall) state_nx = WAIT;
            end
            WAIT: begin
                if (done || timeout) state_nx = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_sel    <= '0;
            bus_data_m <= '0;
            cnt        <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (take) begin
                bus_we     <= cmd_we;
                bus_addr   <= cmd_addr;
                bus_sel    <= cmd_sel;
                bus_data_m <= cmd_data;
                cnt        <= '0;
            end else if (busy) begin
                cnt <= cnt_inc;
            end
            // a real response beats a coincident timeout; err beats ack
            if (done) begin
                rsp_err  <= bus_err;
                rsp_data <= (bus_err || bus_we) ? 32'h0 : bus_data_s;
            end else if (timeout) begin
                rsp_err  <= 1'b1;
                rsp_data <= 32'h0;
            end
        end
    end

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Single-outstanding initiator for the team's 32-bit pipelined Wishbone-style bus. It accepts one read or write command at a time on a valid/ready command port and drives `cyc`/`stb` until the target accepts (`stall` low). It then waits for `ack` or `err`, or for a timeout, and returns the result on a valid/ready response port. It sits between a CPU-side or DMA-side requester and bus targets such as the on-chip RAM.

## Interface
- `AddrWidth`, default 30: word-address width of `bus_addr` and `cmd_addr`.
- `TimeoutCycles`, default 255: maximum cycles from `stb` assertion to `ack`/`err`. A value of 0 disables the timeout.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: block can accept a command.
- `cmd_we`  in  1: 1 = write, 0 = read.
- `cmd_addr`  in  AddrWidth: word address.
- `cmd_data`  in  32: write data.
- `cmd_sel`  in  4: byte lane enables.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: response consumed.
- `rsp_data`  out  32: read data; 0 for writes and errors.
- `rsp_err`  out  1: bus error or timeout.
- `bus_cyc`, `bus_stb`, `bus_we`  out  1 each: bus cycle, strobe, write enable.
- `bus_addr`  out  AddrWidth; `bus_sel`  out  4; `bus_data_m`  out  32.
- `bus_data_s`  in  32; `bus_ack`, `bus_stall`, `bus_err`  in  1 each.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - `cmd_ready` = 1 (0 while `rst_n` low).
  - On `cmd_valid`: register `we`, `addr`, `sel`, `data` onto the bus outputs; go to REQ.
- **REQ**
  - `bus_cyc` = `bus_stb` = 1; bus outputs held stable.
  - When `bus_stall` = 0, the strobe is accepted:
    - if `bus_ack` or `bus_err` is also high in that cycle, go to RESP;
    - otherwise go to WAIT.
  - `ack`/`err` while `stall` = 1 is ignored.
- **WAIT**
  - `bus_cyc` = 1, `bus_stb` = 0.
  - On `bus_ack` or `bus_err`, go to RESP.
- **RESP**
  - `bus_cyc` = 0, `rsp_valid` = 1.
  - `rsp_data`/`rsp_err` held until `rsp_ready`, then go to IDLE.
- **Response capture** (on the completing edge):
  - `ack` on a read: `rsp_data` = `bus_data_s`, `rsp_err` = 0.
  - `ack` on a write: `rsp_data` = 0, `rsp_err` = 0.
  - `err`: `rsp_err` = 1, `rsp_data` = 0.
  - `ack` and `err` together: `err` wins.
- **Timeout**
  - Counter width is `$clog2(TimeoutCycles+1)`. It clears on entry to REQ and increments each cycle in REQ and WAIT.
  - On reaching `TimeoutCycles` with no `ack`/`err`, go to RESP with `rsp_err` = 1 and drop `cyc`/`stb`.
  - Counter saturates and never wraps.
- `ack`/`err` seen in IDLE or RESP are ignored; they never change the response.
- Only one transaction is ever outstanding; `cmd_ready` = 0 outside IDLE.

## Timing
- **Reset values:**
  - 0: `bus_cyc`, `bus_stb`, `bus_we`, `bus_addr`, `bus_sel`, `bus_data_m`, `rsp_valid`, `rsp_data`, `rsp_err`, `cmd_ready`.
  - State = IDLE; counter = 0.
- **Reset mid-operation:** `cyc`/`stb` and `rsp_valid` drop asynchronously and the transaction is abandoned. A late `ack` after reset release lands in IDLE and is ignored.
- **Zero-wait target** (no stall, `ack` one cycle after accepted `stb`):
  - Command accepted at edge E0.
  - `stb` high during E0–E1; `ack` high during E1–E2.
  - `rsp_valid` high from E2.
  - Three edges from acceptance to response consumed, if `rsp_ready` = 1 at E3.
- **Stall:** each stall cycle adds one cycle; the bus outputs must not change while `stb` = 1 and `stall` = 1.
- **Back-to-back:** the next command is accepted no earlier than the cycle after the RESP handshake. `cyc` is low for at least one cycle between transactions.
- **Timeout:** when `TimeoutCycles` = N, `rsp_valid` rises on the edge N cycles after REQ entry.

## Test plan
- **Write then read:**
  - Stimulus: write `addr` 0x10, data 0xDEADBEEF, `sel` 0xF, then read 0x10 against a zero-wait RAM model.
  - Required: `rsp_data` 0xDEADBEEF, `rsp_err` 0, `stb` high exactly 1 cycle per transaction.
- **Byte lanes:**
  - Stimulus: write 0x11223344 with `sel` 0x4 over 0x00000000, then read.
  - Required: read returns 0x00220000.
- **Stall:**
  - Stimulus: target holds `stall` for 3 cycles.
  - Required: `stb` high for 4 cycles with `addr`/`data`/`sel` constant; `rsp_valid` 3 cycles later than the no-stall case.
- **Error and timeout:**
  - Stimulus: target returns `err`, then a separate silent target with `TimeoutCycles` = 8.
  - Required: both give `rsp_err` = 1 and `rsp_data` = 0; in the timeout case `cyc` drops and `rsp_valid` rises 8 cycles after REQ entry.
- **Response backpressure:**
  - Stimulus: hold `rsp_ready` = 0 for 5 cycles while a second command is pending.
  - Required: `rsp_valid`/`rsp_data` stable and `cmd_ready` = 0 throughout; the second command is accepted the cycle after the handshake.
- **Reset mid-transfer:**
  - Stimulus: assert `rst_n` low during WAIT; target issues `ack` after release.
  - Required: all outputs 0 immediately; no `rsp_valid` after release.
